// File: rtl/muldiv_hilo.sv
// HI/LO execution unit: single-cycle multiply, 32-step restoring divide,
// MTHI/MTLO/MFHI/MFLO access to the architectural HI/LO pair.
package muldiv_hilo_pkg;
  localparam logic [4:0] MULT_CONTROL  = 5'b11000;
  localparam logic [4:0] MULTU_CONTROL = 5'b11001;
  localparam logic [4:0] DIV_CONTROL   = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b11011;
  localparam logic [4:0] MTHI_CONTROL  = 5'b11100;
  localparam logic [4:0] MTLO_CONTROL  = 5'b11101;
  localparam logic [4:0] MFHI_CONTROL  = 5'b11110;
  localparam logic [4:0] MFLO_CONTROL  = 5'b11111;
endpackage

module muldiv_hilo
  import muldiv_hilo_pkg::*;
#(
  parameter logic [31:0] HILO_RST = 32'h0000_0000,
  parameter int unsigned DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic [4:0]  alucontrol,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] mf_result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST = 5'(DIV_ITER - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;

  logic        wr_ok;
  logic        is_mult, is_multu, is_div, is_divu;
  logic        is_mthi, is_mtlo;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_abs, b_abs;
  logic [32:0] sh;
  logic        ge;
  logic [31:0] diff;

  assign wr_ok    = en & ~flush;
  assign is_mult  = alucontrol == MULT_CONTROL;
  assign is_multu = alucontrol == MULTU_CONTROL;
  assign is_div   = alucontrol == DIV_CONTROL;
  assign is_divu  = alucontrol == DIVU_CONTROL;
  assign is_mthi  = alucontrol == MTHI_CONTROL;
  assign is_mtlo  = alucontrol == MTLO_CONTROL;

  assign prod_s = $signed(src_a) * $signed(src_b);
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};
  assign a_abs  = src_a[31] ? -src_a : src_a;
  assign b_abs  = src_b[31] ? -src_b : src_b;

  // Partial remainder is < 2*divisor, so 33 bits cover the trial compare
  assign sh   = {rem_q, quo_q[31]};
  assign ge   = sh >= {1'b0, dvs_q};
  assign diff = sh[31:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    stall_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_ok) begin
          unique case (1'b1)
            is_mult:  {hi_d, lo_d} = prod_s;
            is_multu: {hi_d, lo_d} = prod_u;
            is_mthi:  hi_d = src_a;
            is_mtlo:  lo_d = src_a;
            is_div, is_divu: begin
              stall_o = 1'b1;
              quo_d   = is_div ? a_abs : src_a;
              dvs_d   = is_div ? b_abs : src_b;
              rem_d   = '0;
              qneg_d  = is_div & (src_a[31] ^ src_b[31]);
              rneg_d  = is_div & src_a[31];
              dz_d    = src_b == '0;
              cnt_d   = '0;
              state_d = S_DIV;
            end
            default: ;
          endcase
        end
      end
      S_DIV: begin
        stall_o = 1'b1;
        rem_d   = ge ? diff : sh[31:0];
        quo_d   = {quo_q[30:0], ge};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        // A zero divisor leaves quotient all-ones and remainder = dividend
        lo_d    = (qneg_q & ~dz_q) ? -quo_q : quo_q;
        hi_d    = (rneg_q & ~dz_q) ? -rem_q : rem_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      stall_o = 1'b0;
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= HILO_RST;
      lo_q    <= HILO_RST;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  always_comb begin
    mf_result = '0;
    if (alucontrol == MFHI_CONTROL) mf_result = hi_q;
    if (alucontrol == MFLO_CONTROL) mf_result = lo_q;
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Bench for muldiv_hilo: vector table through a scoreboard queue,
// plus hand sequences for flush, reset mid-divide and MT/MF hazards.
module tb_muldiv_hilo;
  import muldiv_hilo_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        flush;
  logic [4:0]  alucontrol;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] mf_result;

  muldiv_hilo dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .alucontrol(alucontrol),
    .src_a     (src_a),
    .src_b     (src_b),
    .stall_o   (stall_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .mf_result (mf_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } exp_t;

  vec_t vecs[12];
  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   n;
    bit   ok;
    @(negedge clk);
    en = 1'b1;
    alucontrol = v.op;
    src_a = v.a;
    src_b = v.b;
    sbq.push_back('{v.hi, v.lo, v.stalls});
    n = 0;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (!stall_o) begin
        ok = 1'b1;
        break;
      end
      n++;
      @(negedge clk);
    end
    chk($sformatf("v%0d_timeout", idx), 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    en = 1'b0;
    alucontrol = 5'd0;
    e = sbq.pop_front();
    chk($sformatf("v%0d_stalls", idx), 32'(n), 32'(e.stalls));
    chk($sformatf("v%0d_hi", idx), hi_o, e.hi);
    chk($sformatf("v%0d_lo", idx), lo_o, e.lo);
  endtask

  initial begin
    vecs[0]  = '{MULT_CONTROL,  32'hFFFF_FFFE, 32'd3,
                 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0};
    vecs[1]  = '{MULTU_CONTROL, 32'hFFFF_FFFE, 32'd3,
                 32'h0000_0002, 32'hFFFF_FFFA, 0};
    vecs[2]  = '{DIV_CONTROL,   32'hFFFF_FFF9, 32'd2,
                 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3]  = '{DIVU_CONTROL,  32'd100, 32'd7,
                 32'd2, 32'd14, 33};
    vecs[4]  = '{DIVU_CONTROL,  32'd5, 32'd0,
                 32'd5, 32'hFFFF_FFFF, 33};
    vecs[5]  = '{DIV_CONTROL,   32'h8000_0000, 32'hFFFF_FFFF,
                 32'd0, 32'h8000_0000, 33};
    vecs[6]  = '{MTHI_CONTROL,  32'hDEAD_BEEF, 32'd0,
                 32'hDEAD_BEEF, 32'h8000_0000, 0};
    vecs[7]  = '{MTLO_CONTROL,  32'h0000_1234, 32'd0,
                 32'hDEAD_BEEF, 32'h0000_1234, 0};
    vecs[8]  = '{DIV_CONTROL,   32'd7, 32'hFFFF_FFFE,
                 32'd1, 32'hFFFF_FFFD, 33};
    vecs[9]  = '{MULTU_CONTROL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'hFFFF_FFFE, 32'h0000_0001, 0};
    vecs[10] = '{DIV_CONTROL,   32'hFFFF_FFF9, 32'hFFFF_FFFE,
                 32'hFFFF_FFFF, 32'd3, 33};
    vecs[11] = '{MFHI_CONTROL,  32'h5555_5555, 32'hAAAA_AAAA,
                 32'hFFFF_FFFF, 32'd3, 0};

    rst = 1'b1;
    en = 1'b0;
    flush = 1'b0;
    alucontrol = MFHI_CONTROL;
    src_a = '0;
    src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mfhi", mf_result, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // en low and unlisted code: no writes, no stall
    @(negedge clk);
    en = 1'b0;
    alucontrol = MULT_CONTROL;
    src_a = 32'd9;
    src_b = 32'd9;
    @(posedge clk);
    #1;
    chk("en0_lo", lo_o, 32'd3);
    @(negedge clk);
    en = 1'b1;
    alucontrol = 5'b00001;
    #1;
    chk("unl_stall", 32'(stall_o), 32'd0);
    chk("unl_mf", mf_result, 32'd0);
    @(posedge clk);
    #1;
    chk("unl_hi", hi_o, 32'hFFFF_FFFF);

    // flush at iteration 10 of a divide
    @(negedge clk);
    en = 1'b1;
    alucontrol = DIVU_CONTROL;
    src_a = 32'd100;
    src_b = 32'd7;
    repeat (11) @(negedge clk);
    #1;
    chk("fl_pre_stall", 32'(stall_o), 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    alucontrol = MFLO_CONTROL;
    #1;
    chk("fl_idle", 32'(stall_o), 32'd0);
    chk("fl_hi", hi_o, 32'hFFFF_FFFF);
    chk("fl_lo", lo_o, 32'd3);
    chk("fl_mflo", mf_result, 32'd3);
    en = 1'b0;
    run_vec(12, '{MTLO_CONTROL, 32'h0000_1234, 32'd0,
                  32'hFFFF_FFFF, 32'h0000_1234, 0});

    // MTHI then MFHI in consecutive cycles
    @(negedge clk);
    en = 1'b1;
    alucontrol = MTHI_CONTROL;
    src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    alucontrol = MFHI_CONTROL;
    #1;
    chk("b2b_mfhi", mf_result, 32'hDEAD_BEEF);
    alucontrol = MFLO_CONTROL;
    #1;
    chk("b2b_mflo", mf_result, 32'h0000_1234);

    // reset mid-divide
    @(negedge clk);
    alucontrol = DIV_CONTROL;
    src_a = 32'd1000;
    src_b = 32'd3;
    repeat (5) @(negedge clk);
    #1;
    chk("rd_pre_stall", 32'(stall_o), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b0;
    #1;
    chk("rd_hi", hi_o, 32'd0);
    chk("rd_lo", lo_o, 32'd0);
    chk("rd_stall", 32'(stall_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
- EX-stage execution unit that consumes the 5-bit alucontrol codes produced by the ALU decoder for the HI/LO instruction group: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- Owns the architectural HI/LO registers.
- Multiplies in one cycle. Divides with a multi-cycle radix-2 restoring divider and stalls the pipeline while busy.
- Sits beside the main ALU. The datapath muxes mf_result into the EX result when alucontrol is MFHI/MFLO.

Parameters:
HILO_RST, 32'h0000_0000, reset value of HI and LO
DIV_ITER, 32, divider iterations; only 32 is supported, present for documentation and assertion

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  EX-stage instruction valid (not a bubble)
flush  in  1  exception/pipeline flush of EX stage; cancels and suppresses all writes
alucontrol  in  5  operation code, defines2.vh *_CONTROL encodings
src_a  in  32  rs value (dividend / multiplicand / MTHI-MTLO source)
src_b  in  32  rt value (divisor / multiplier)
stall_o  out  1  hold IF..EX; combinational
hi_o  out  32  current HI register
lo_o  out  32  current LO register
mf_result  out  32  hi_o if alucontrol==MFHI_CONTROL, lo_o if MFLO_CONTROL, else 0; combinational

Behaviour:
- Reset (rst=1 at clock edge): HI=LO=HILO_RST, state=IDLE, iteration counter=0, divider working regs=0. stall_o=0 after reset.
- Write qualifier: wr_ok = en & ~flush.
- FSM states:
  - IDLE: accepts operations.
  - DIV: iterating.
  - DONE: commits the divide result, releases the stall.
- IDLE behaviour, when wr_ok:
  - MULT: {HI,LO} <= signed src_a*src_b (64-bit) at end of cycle.
  - MULTU: {HI,LO} <= unsigned src_a*src_b at end of cycle.
  - MTHI: HI<=src_a at end of cycle; LO unchanged.
  - MTLO: LO<=src_a at end of cycle; HI unchanged.
  - MFHI/MFLO: no state change. mf_result reflects the registers in the same cycle.
  - Single-cycle ops: zero added latency; stall_o=0.
  - Back-to-back MTHI then MFHI in consecutive EX cycles returns the new value with no forwarding, since the write lands at the clock edge.
- DIV/DIVU start, in IDLE with wr_ok:
  - stall_o=1 combinationally that cycle.
  - Latch |src_a| and |src_b| (DIV) or raw values (DIVU).
  - Latch quotient sign = sign(a)^sign(b), remainder sign = sign(a) (DIV only), and a divide-by-zero flag.
  - Clear counter; go to DIV.
- DIV state:
  - One restoring step per cycle (shift remainder/quotient, trial subtract, keep if non-negative).
  - Counter 0..31; after step 31 go to DONE.
  - stall_o=1 throughout.
- DONE state:
  - stall_o=0.
  - At end of cycle, LO<=quotient and HI<=remainder after sign correction (two's-complement negate where the sign bit is set); go to IDLE.
  - The held DIV instruction is still presented in DONE but must not restart, because the start condition requires IDLE.
- Total: a divide occupies EX for 34 cycles (1 start + 32 iterate + 1 done); stall_o is high for the first 33 of them.
- Signed edge case: 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0 (natural 32-bit wrap).
- Divide by zero: same 34-cycle latency. LO=0xFFFF_FFFF, HI=src_a as latched, no sign correction, for both DIV and DIVU.
- Flush:
  - flush=1 in any state forces stall_o=0 that cycle and returns state to IDLE at the edge.
  - HI/LO are not written.
  - flush in IDLE suppresses MULT/MT*/DIV start.
- en=0 in IDLE: no write, no start. en is ignored in DIV/DONE; the operation runs to completion unless flushed.
- Unlisted alucontrol codes: no state change, stall_o=0, mf_result=0.
- rst has priority over flush and everything else, including mid-divide: it aborts immediately and HI/LO return to HILO_RST.

Test Plan:
- Reset then MFHI/MFLO -> mf_result=0; stall_o=0; hi_o=lo_o=0.
- MULT a=0xFFFF_FFFE (-2), b=3 -> next cycle HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. MULTU same operands -> HI=0x0000_0002, LO=0xFFFF_FFFA.
- DIV a=-7 (0xFFFF_FFF9), b=2, held by stall -> stall_o high exactly 33 cycles. Then LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). DIVU 100/7 -> LO=14, HI=2.
- DIVU 5/0 -> 34-cycle occupancy, LO=0xFFFF_FFFF, HI=5. DIV 0x8000_0000/0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- DIV started, flush asserted at iteration 10 -> stall_o drops that cycle, state IDLE next cycle, HI/LO keep prior values. A following MTLO 0x1234 writes LO=0x1234.
- MTHI 0xDEAD_BEEF followed immediately by MFHI -> mf_result=0xDEAD_BEEF. rst asserted mid-divide -> HI=LO=0, stall_o=0 next cycle.
